alu_result_accumulator: RTL and testbench
=========================================

// Module: alu_result_accumulator
// PURPOSE
//  Sequential command/accumulator stage wrapped around the combinational BreadBoard ALU.
//  Accepts op commands over a valid/ready handshake and drives the ALU operands:
//  input1 = accumulator, input2 = command data.
//  Waits a fixed settle time, captures output1/err_code into a 32-bit accumulator and a
//  sticky error register, then pulses done. Turns the stateless ALU into a running calculator.
// PARAMETERS
//  WIDTH          16  ALU operand width (input1/input2)
//  RES_WIDTH      32  ALU result / accumulator width
//  SETTLE_CYCLES  2   clock edges allowed for ALU settling, min 1
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          reset, asynchronous, active-high
//  cmd_valid    in   1          command present
//  cmd_ready    out  1          block idle, command accepted when valid&ready
//  cmd_op       in   4          0 add, 1 sub, 2 mul, 3 div, 4 mod, 8 CLEAR, 9 LOAD; others illegal
//  cmd_data     in   WIDTH      operand B (ALU ops) or load value (LOAD)
//  alu_input1   out  WIDTH      to ALU input1 = acc[WIDTH-1:0], registered
//  alu_input2   out  WIDTH      to ALU input2, registered
//  alu_op_code  out  4          to ALU op_code, registered
//  alu_output1  in   RES_WIDTH  ALU result
//  alu_err_code in   2          ALU error ([1] = divide/mod by zero)
//  acc          out  RES_WIDTH  accumulator, signed
//  err_sticky   out  4          [1:0] ALU err OR-accumulated, [2] operand truncation, [3] illegal op
//  done         out  1          one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; acc=0; err_sticky=0; done=0; alu_input1/2=0; alu_op_code=0; cmd_ready=1.
//  cmd_ready = (state==IDLE). cmd_valid while busy is ignored; no queuing.
//  done defaults to 0 each edge; it is set only as listed below.
//  FSM: IDLE, SETTLE, CAPTURE.
//  IDLE, accept edge E0, by cmd_op:
//   CLEAR (8): acc<=0, err_sticky<=0, done<=1; stay IDLE.
//   LOAD (9): acc<=sign-extended cmd_data, done<=1; err_sticky unchanged; stay IDLE.
//   illegal (5-7, 10-15): err_sticky[3]<=1, done<=1; acc unchanged; stay IDLE.
//   ALU op (0-4):
//    alu_input1<=acc[WIDTH-1:0], alu_input2<=cmd_data, alu_op_code<=cmd_op.
//    cnt<=SETTLE_CYCLES-1. Next state = CAPTURE if SETTLE_CYCLES==1, else SETTLE.
//    If acc is outside signed WIDTH range (acc[RES_WIDTH-1:WIDTH-1] not all equal): err_sticky[2]<=1; op still proceeds.
//  SETTLE: each edge cnt<=cnt-1. The edge on which cnt becomes 0 moves the FSM to CAPTURE.
//  CAPTURE edge:
//   If alu_err_code!=0: err_sticky[1:0] |= alu_err_code; acc unchanged.
//   Else: acc<=alu_output1.
//   Then done<=1, state->IDLE.
//  Latency: ALU op completes SETTLE_CYCLES+1 edges after E0. done and cmd_ready both go high after the capture edge.
//   CLEAR/LOAD/illegal: done is high in the cycle after E0; cmd_ready stays high.
//  ALU operands hold their last value while IDLE; the ALU output is sampled only in CAPTURE.
//  Arithmetic: no arithmetic in this block besides sign-extension; acc is the ALU result verbatim, wrap included.
//  Back-to-back: a new command is accepted in the same cycle done is high.
//  Reset mid-SETTLE/CAPTURE: operation aborted, no done pulse, reset values immediately.
// CONFIGURATION
//  ACC_LOCK_ON_ERR_EN defined:
//   If err_sticky!=0 at acceptance, every op except CLEAR is consumed as a no-op:
//   handshake completes, done pulses next cycle, acc/err/ALU regs unchanged, FSM stays IDLE.
//   CLEAR is the only recovery.
//  Not defined: errors only accumulate; all commands execute normally.
// TESTING (bench ALU model = BreadBoard semantics, SETTLE_CYCLES=2)
//  1. rst=1 then release -> acc=0, err_sticky=0, cmd_ready=1, done=0, alu_op_code=0.
//  2. LOAD 32000; DIV 16000 -> alu_input1=32000, alu_input2=16000;
//     done exactly 3 edges after accept; acc=2, err_sticky=0.
//  3. LOAD 11; DIV 0 -> alu_err_code=2'b10 captured; acc=11, err_sticky=4'b0010.
//  4. LOAD 32000; MUL 16000 (acc=512000000); ADD 1 -> err_sticky[2]=1;
//     alu_input1=512000000[15:0] = -32768 (0x8000). Then CLEAR -> acc=0, err_sticky=0.
//  5. cmd_op=6 -> err_sticky=4'b1000, acc unchanged.
//     With ACC_LOCK_ON_ERR_EN: following LOAD 5 gives done, acc unchanged.
//     Without the macro: acc=5.
//  6. Assert rst during SETTLE of a DIV -> no done, all outputs at reset values;
//     cmd_valid held high during busy is not accepted until IDLE.

Source files
------------

// File: rtl/alu_result_accumulator_if.sv
// Command handshake and ALU-side bus for alu_result_accumulator.
// slave = accumulator side, master = command source plus the combinational ALU.
interface alu_result_accumulator_if #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 32
);
  // cmd_valid/cmd_ready: a command transfers on a rising edge where both are high;
  // the source holds cmd_op/cmd_data stable while cmd_valid is high and not yet accepted.
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_op;
  logic [WIDTH-1:0]     cmd_data;
  logic [WIDTH-1:0]     alu_input1;
  logic [WIDTH-1:0]     alu_input2;
  logic [3:0]           alu_op_code;
  logic [RES_WIDTH-1:0] alu_output1;
  logic [1:0]           alu_err_code;
  logic [RES_WIDTH-1:0] acc;
  logic [3:0]           err_sticky;
  logic                 done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_output1, alu_err_code,
    output cmd_ready, alu_input1, alu_input2, alu_op_code, acc, err_sticky, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_output1, alu_err_code,
    input  cmd_ready, alu_input1, alu_input2, alu_op_code, acc, err_sticky, done
  );
endinterface

// File: rtl/alu_result_accumulator.sv
// Command/accumulator stage around a combinational ALU: drive operands, wait, capture.
// Optional ACC_LOCK_ON_ERR_EN: after any sticky error, only CLEAR executes.
module alu_result_accumulator #(
  parameter int WIDTH         = 16,
  parameter int RES_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_accumulator_if.slave  bus,
  output logic [1:0]               state_dbg
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [3:0] OP_CLEAR = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [RES_WIDTH-1:0] acc_q;
  logic [3:0]           err_q;
  logic                 done_q;
  logic [WIDTH-1:0]     in1_q;
  logic [WIDTH-1:0]     in2_q;
  logic [3:0]           op_q;

  logic is_alu_op;
  logic is_clear;
  logic is_load;
  logic acc_trunc;
  logic lock_hit;

  assign is_alu_op = (bus.cmd_op <= 4'd4);
  assign is_clear  = (bus.cmd_op == OP_CLEAR);
  assign is_load   = (bus.cmd_op == OP_LOAD);
  // acc fits in a signed WIDTH operand only if all bits from WIDTH-1 upward agree
  assign acc_trunc = ~((&acc_q[RES_WIDTH-1:WIDTH-1]) | ~(|acc_q[RES_WIDTH-1:WIDTH-1]));

`ifdef ACC_LOCK_ON_ERR_EN
  assign lock_hit = (err_q != 4'd0) && !is_clear;
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_q  <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
      in1_q  <= '0;
      in2_q  <= '0;
      op_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (lock_hit) begin
              done_q <= 1'b1;
            end else if (is_clear) begin
              acc_q  <= '0;
              err_q  <= '0;
              done_q <= 1'b1;
            end else if (is_load) begin
              acc_q  <= {{(RES_WIDTH-WIDTH){bus.cmd_data[WIDTH-1]}}, bus.cmd_data};
              done_q <= 1'b1;
            end else if (is_alu_op) begin
              in1_q <= acc_q[WIDTH-1:0];
              in2_q <= bus.cmd_data;
              op_q  <= bus.cmd_op;
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              if (acc_trunc) err_q[2] <= 1'b1;
              state <= (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
            end else begin
              err_q[3] <= 1'b1;
              done_q   <= 1'b1;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          if (bus.alu_err_code != 2'b00) err_q[1:0] <= err_q[1:0] | bus.alu_err_code;
          else                           acc_q      <= bus.alu_output1;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.alu_input1  = in1_q;
  assign bus.alu_input2  = in2_q;
  assign bus.alu_op_code = op_q;
  assign bus.acc         = acc_q;
  assign bus.err_sticky  = err_q;
  assign bus.done        = done_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Directed bench for alu_result_accumulator with a behavioural signed ALU on the bus.
module tb_alu_result_accumulator;
  logic clk;
  logic rst;
  logic [1:0] state_dbg;
  int n_cmp;
  int n_bad;

  alu_result_accumulator_if #(.WIDTH(16), .RES_WIDTH(32)) bus ();

  alu_result_accumulator #(.WIDTH(16), .RES_WIDTH(32), .SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // signed ALU model: add, sub, mul, div, mod; div/mod by zero flags err[1]
  logic signed [31:0] a32;
  logic signed [31:0] b32;
  always_comb begin
    a32 = 32'($signed(bus.alu_input1));
    b32 = 32'($signed(bus.alu_input2));
    bus.alu_output1  = '0;
    bus.alu_err_code = 2'b00;
    case (bus.alu_op_code)
      4'd0: bus.alu_output1 = a32 + b32;
      4'd1: bus.alu_output1 = a32 - b32;
      4'd2: bus.alu_output1 = a32 * b32;
      4'd3: if (b32 == 0) bus.alu_err_code = 2'b10; else bus.alu_output1 = a32 / b32;
      4'd4: if (b32 == 0) bus.alu_err_code = 2'b10; else bus.alu_output1 = a32 % b32;
      default: bus.alu_output1 = '0;
    endcase
  end

  // driver: one command, returns edges from accept until done is seen (10 = timeout)
  task automatic issue(input logic [3:0] op, input logic [15:0] data, output int lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0;
    bus.cmd_data = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.acc !== 32'd0) begin n_bad++; $display("FAIL reset_acc got %0h want 0", bus.acc); end
    n_cmp++; if (bus.err_sticky !== 4'd0) begin n_bad++; $display("FAIL reset_err got %0h want 0", bus.err_sticky); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.alu_op_code !== 4'd0) begin n_bad++; $display("FAIL reset_opcode got %0h want 0", bus.alu_op_code); end
  endtask

  task automatic test_div();
    int lat;
    issue(4'd9, 16'd32000, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL load_latency got %0d want 1", lat); end
    n_cmp++; if (bus.acc !== 32'd32000) begin n_bad++; $display("FAIL load_acc got %0d want 32000", bus.acc); end
    issue(4'd3, 16'd16000, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL div_latency got %0d want 3", lat); end
    n_cmp++; if (bus.alu_input1 !== 16'd32000) begin n_bad++; $display("FAIL div_in1 got %0d want 32000", bus.alu_input1); end
    n_cmp++; if (bus.alu_input2 !== 16'd16000) begin n_bad++; $display("FAIL div_in2 got %0d want 16000", bus.alu_input2); end
    n_cmp++; if (bus.alu_op_code !== 4'd3) begin n_bad++; $display("FAIL div_opcode got %0d want 3", bus.alu_op_code); end
    n_cmp++; if (bus.acc !== 32'd2) begin n_bad++; $display("FAIL div_acc got %0d want 2", bus.acc); end
    n_cmp++; if (bus.err_sticky !== 4'd0) begin n_bad++; $display("FAIL div_err got %0h want 0", bus.err_sticky); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL div_ready got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(4'd9, 16'd11, lat);
    issue(4'd3, 16'd0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL div0_latency got %0d want 3", lat); end
    n_cmp++; if (bus.acc !== 32'd11) begin n_bad++; $display("FAIL div0_acc got %0d want 11", bus.acc); end
    n_cmp++; if (bus.err_sticky !== 4'b0010) begin n_bad++; $display("FAIL div0_err got %b want 0010", bus.err_sticky); end
    issue(4'd8, 16'd0, lat);
    n_cmp++; if (bus.err_sticky !== 4'b0000) begin n_bad++; $display("FAIL div0_clear got %b want 0000", bus.err_sticky); end
  endtask

  task automatic test_truncation();
    int lat;
    issue(4'd9, 16'd32000, lat);
    issue(4'd2, 16'd16000, lat);
    n_cmp++; if (bus.acc !== 32'd512000000) begin n_bad++; $display("FAIL mul_acc got %0d want 512000000", bus.acc); end
    n_cmp++; if (bus.err_sticky !== 4'b0000) begin n_bad++; $display("FAIL mul_err got %b want 0000", bus.err_sticky); end
    issue(4'd0, 16'd1, lat);
    n_cmp++; if (bus.alu_input1 !== 16'h8000) begin n_bad++; $display("FAIL trunc_in1 got %h want 8000", bus.alu_input1); end
    n_cmp++; if (bus.err_sticky !== 4'b0100) begin n_bad++; $display("FAIL trunc_err got %b want 0100", bus.err_sticky); end
    n_cmp++; if (bus.acc !== 32'hFFFF_8001) begin n_bad++; $display("FAIL trunc_acc got %h want ffff8001", bus.acc); end
    issue(4'd8, 16'd0, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL clear_latency got %0d want 1", lat); end
    n_cmp++; if (bus.acc !== 32'd0) begin n_bad++; $display("FAIL clear_acc got %0d want 0", bus.acc); end
    n_cmp++; if (bus.err_sticky !== 4'b0000) begin n_bad++; $display("FAIL clear_err got %b want 0000", bus.err_sticky); end
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] exp_acc;
    issue(4'd9, 16'hFFF0, lat);
    n_cmp++; if (bus.acc !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL load_sext got %h want fffffff0", bus.acc); end
    issue(4'd6, 16'd3, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL illegal_latency got %0d want 1", lat); end
    n_cmp++; if (bus.err_sticky !== 4'b1000) begin n_bad++; $display("FAIL illegal_err got %b want 1000", bus.err_sticky); end
    n_cmp++; if (bus.acc !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL illegal_acc got %h want fffffff0", bus.acc); end
    issue(4'd9, 16'd5, lat);
`ifdef ACC_LOCK_ON_ERR_EN
    exp_acc = 32'hFFFF_FFF0;
`else
    exp_acc = 32'd5;
`endif
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL post_err_load_latency got %0d want 1", lat); end
    n_cmp++; if (bus.acc !== exp_acc) begin n_bad++; $display("FAIL post_err_load_acc got %h want %h", bus.acc, exp_acc); end
    issue(4'd8, 16'd0, lat);
    n_cmp++; if (bus.err_sticky !== 4'b0000) begin n_bad++; $display("FAIL illegal_clear got %b want 0000", bus.err_sticky); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    issue(4'd9, 16'd100, lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd3;
    bus.cmd_data  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (state_dbg !== 2'd1) begin n_bad++; $display("FAIL midop_state got %0d want 1", state_dbg); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.acc !== 32'd0) begin n_bad++; $display("FAIL midrst_acc got %0d want 0", bus.acc); end
    n_cmp++; if (bus.alu_input1 !== 16'd0 || bus.alu_input2 !== 16'd0 || bus.alu_op_code !== 4'd0) begin
      n_bad++; $display("FAIL midrst_alu_regs got %h/%h/%h want 0/0/0", bus.alu_input1, bus.alu_input2, bus.alu_op_code);
    end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", bus.done); end
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.acc !== 32'd0) begin
      n_bad++; $display("FAIL midrst_aborted got done=%b acc=%0d want done=0 acc=0", bus.done, bus.acc);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(4'd9, 16'd50, lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd3;
    bus.cmd_data  = 16'd5;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op   = 4'd9;
    bus.cmd_data = 16'd999;
    n_cmp++; if (bus.cmd_ready !== 1'b0 || bus.acc !== 32'd50) begin
      n_bad++; $display("FAIL busy_ignore got ready=%b acc=%0d want ready=0 acc=50", bus.cmd_ready, bus.acc);
    end
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_div_latency got %0d want 3", lat); end
    n_cmp++; if (bus.acc !== 32'd10) begin n_bad++; $display("FAIL b2b_div_acc got %0d want 10", bus.acc); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.done !== 1'b1 || bus.acc !== 32'd999) begin
      n_bad++; $display("FAIL b2b_load got done=%b acc=%0d want done=1 acc=999", bus.done, bus.acc);
    end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.acc !== 32'd999) begin
      n_bad++; $display("FAIL b2b_idle got done=%b acc=%0d want done=0 acc=999", bus.done, bus.acc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_div();
    test_div_zero();
    test_truncation();
    test_illegal();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
